// File: rtl/servo_keyframe_interp.sv
// ============================================================================
// Module   : servo_keyframe_interp
// Brief    : Slew-limited keyframe interpolator feeding the servo pulse timers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_keyframe_interp #(
   parameter int STEP      = 1,
   parameter int MIN_PULSE = 15,
   parameter int MAX_PULSE = 59,
   parameter int CENTER    = 37,
   parameter int HOLD_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic              kf_valid,
   output logic              kf_ready,
   input  logic [63:0]       kf_data,
   input  logic [HOLD_W-1:0] kf_hold,
   input  logic              abort,
   output logic [63:0]       data,
   output logic              busy,
   output logic              done
);

   localparam logic [15:0] c_step   = 16'(STEP);
   localparam logic [15:0] c_min    = 16'(MIN_PULSE);
   localparam logic [15:0] c_max    = 16'(MAX_PULSE);
   localparam logic [15:0] c_center = 16'(CENTER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [15:0]       r_pos   [4];
   logic [15:0]       r_tgt   [4];
   logic [15:0]       w_step  [4];
   logic [15:0]       w_clamp [4];
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] r_cnt;
   logic              r_done;
   logic              w_done_set;
   logic              w_all_eq;
   logic              w_accept;

   // Per-channel slew step toward target and input clamping.
   always_comb begin
      w_all_eq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w_clamp[i] = kf_data[16*i +: 16];
         if (w_clamp[i] < c_min) w_clamp[i] = c_min;
         if (w_clamp[i] > c_max) w_clamp[i] = c_max;
         if (r_tgt[i] >= r_pos[i]) begin
            w_step[i] = (r_tgt[i] - r_pos[i] <= c_step) ? r_tgt[i] : r_pos[i] + c_step;
         end else begin
            w_step[i] = (r_pos[i] - r_tgt[i] <= c_step) ? r_tgt[i] : r_pos[i] - c_step;
         end
         if (w_step[i] != r_tgt[i]) w_all_eq = 1'b0;
      end
   end

   assign w_accept = (r_state == IDLE) && kf_valid && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_done_set = 1'b0;
      if (abort) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: if (kf_valid) w_next = MOVE;
            MOVE: begin
               if (frame_tick && w_all_eq) begin
                  if (r_hold == '0) begin
                     w_next     = IDLE;
                     w_done_set = 1'b1;
                  end else begin
                     w_next = HOLD;
                  end
               end
            end
            HOLD: begin
               if (frame_tick && r_cnt <= HOLD_W'(1)) begin
                  w_next     = IDLE;
                  w_done_set = 1'b1;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_pos[i] <= c_center;
            r_tgt[i] <= c_center;
         end
         r_hold <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_done_set;
         // abort freezes positions, targets and the hold counter.
         if (!abort) begin
            if (w_accept) begin
               for (int i = 0; i < 4; i++) r_tgt[i] <= w_clamp[i];
               r_hold <= kf_hold;
            end
            if (r_state == MOVE && frame_tick) begin
               for (int i = 0; i < 4; i++) r_pos[i] <= w_step[i];
               if (w_all_eq) r_cnt <= r_hold;
            end
            if (r_state == HOLD && frame_tick) r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign data     = {r_pos[3], r_pos[2], r_pos[1], r_pos[0]};
   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign kf_ready = (r_state == IDLE) && !abort;

endmodule

`default_nettype wire

// File: tb/tb_servo_keyframe_interp.sv
// ============================================================================
// Module   : tb_servo_keyframe_interp
// Brief    : Scoreboard bench for servo_keyframe_interp with directed keyframes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_keyframe_interp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        kf_valid = 1'b0;
   logic        kf_ready;
   logic [63:0] kf_data = '0;
   logic [7:0]  kf_hold = '0;
   logic        abort = 1'b0;
   logic [63:0] data;
   logic        busy;
   logic        done;
   logic        probe = 1'b0;
   logic        armed = 1'b0;

   typedef struct {
      string       tag;
      logic [63:0] d;
      logic        busy;
      logic        done;
      logic        rdy;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   servo_keyframe_interp dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .kf_valid   (kf_valid),
      .kf_ready   (kf_ready),
      .kf_data    (kf_data),
      .kf_hold    (kf_hold),
      .abort      (abort),
      .data       (data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pk(int c0, int c1, int c2, int c3);
      return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
   endfunction

   task automatic push(string tag, logic [63:0] d, logic b, logic dn, logic r);
      exp_t e;
      e.tag = tag; e.d = d; e.busy = b; e.done = dn; e.rdy = r;
      sb.push_back(e);
   endtask

   task automatic check_one();
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL unexpected_sample: data=%h busy=%0b done=%0b rdy=%0b with empty scoreboard",
                  data, busy, done, kf_ready);
      end else begin
         e = sb.pop_front();
         if (data !== e.d || busy !== e.busy || done !== e.done || kf_ready !== e.rdy) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%0b done=%0b rdy=%0b, want data=%h busy=%0b done=%0b rdy=%0b",
                     e.tag, data, busy, done, kf_ready, e.d, e.busy, e.done, e.rdy);
         end
      end
   endtask

   // Monitor: samples whenever the consumer would load (frame_tick) or on a probe.
   always @(posedge clk) begin
      if (frame_tick || probe) begin
         #2;
         check_one();
      end
   end

   always @(posedge rst) begin
      if (armed) begin
         #1;
         check_one();
      end
   end

   task automatic tick();
      @(negedge clk); frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
   endtask

   task automatic do_probe();
      @(negedge clk); probe = 1'b1;
      @(posedge clk); #1 probe = 1'b0;
   endtask

   task automatic send(logic [63:0] d, logic [7:0] h);
      @(negedge clk); kf_valid = 1'b1; kf_data = d; kf_hold = h;
      @(posedge clk); #1 kf_valid = 1'b0;
   endtask

   task automatic quiet_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   localparam logic [63:0] CTR = 64'h0025_0025_0025_0025;

   initial begin
      int c0, c1, c2, c3;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state, ticks ignored in IDLE.
      push("reset", CTR, 1'b0, 1'b0, 1'b1);
      do_probe();
      for (int t = 0; t < 10; t++) begin
         push("idle_tick", CTR, 1'b0, 1'b0, 1'b1);
         tick();
      end

      // Main move with hold of 2 frames.
      send(pk(40, 37, 30, 59), 8'd2);
      push("after_accept", CTR, 1'b1, 1'b0, 1'b0);
      do_probe();
      for (int t = 1; t <= 24; t++) begin
         c0 = (37 + t > 40) ? 40 : 37 + t;
         c2 = (37 - t < 30) ? 30 : 37 - t;
         c3 = (37 + t > 59) ? 59 : 37 + t;
         push($sformatf("move_t%0d", t), pk(c0, 37, c2, c3), t < 24, t == 24, t == 24);
         tick();
      end
      push("done_single", pk(40, 37, 30, 59), 1'b0, 1'b0, 1'b1);
      do_probe();

      // Clamp of out-of-range targets.
      quiet_reset();
      send(pk(5, 16'hFFFF, 37, 37), 8'd0);
      for (int t = 1; t <= 22; t++) begin
         c0 = (37 - t < 15) ? 15 : 37 - t;
         c1 = (37 + t > 59) ? 59 : 37 + t;
         push($sformatf("clamp_t%0d", t), pk(c0, c1, 37, 37), t < 22, t == 22, t == 22);
         tick();
      end

      // Target equal to position completes on the first tick.
      send(pk(15, 59, 37, 37), 8'd0);
      push("eq_move", pk(15, 59, 37, 37), 1'b1, 1'b0, 1'b0);
      do_probe();
      push("eq_done", pk(15, 59, 37, 37), 1'b0, 1'b1, 1'b1);
      tick();

      // Acceptance coinciding with frame_tick leaves positions alone.
      push("accept_on_tick", pk(15, 59, 37, 37), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      kf_valid = 1'b1; kf_data = pk(20, 59, 37, 37); kf_hold = 8'd0; frame_tick = 1'b1;
      @(posedge clk); #1 kf_valid = 1'b0; frame_tick = 1'b0;
      for (int t = 1; t <= 5; t++) begin
         push($sformatf("post_accept_t%0d", t), pk(15 + t, 59, 37, 37), t < 5, t == 5, t == 5);
         tick();
      end

      // Abort at tick 6 of a move: frozen at tick-5 values, no done.
      send(pk(40, 59, 37, 37), 8'd0);
      for (int t = 1; t <= 5; t++) begin
         push($sformatf("abort_pre_t%0d", t), pk(20 + t, 59, 37, 37), 1'b1, 1'b0, 1'b0);
         tick();
      end
      push("abort_frozen", pk(25, 59, 37, 37), 1'b0, 1'b0, 1'b1);
      @(negedge clk); abort = 1'b1; frame_tick = 1'b1;
      #1;
      total++;
      if (kf_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_during_abort: got %0b want 0", kf_ready);
      end
      @(posedge clk); #1 abort = 1'b0; frame_tick = 1'b0;
      push("abort_idle_tick", pk(25, 59, 37, 37), 1'b0, 1'b0, 1'b1);
      tick();

      // Async reset in the middle of HOLD.
      send(pk(27, 59, 37, 37), 8'd5);
      push("hold_t1", pk(26, 59, 37, 37), 1'b1, 1'b0, 1'b0);
      tick();
      push("hold_t2", pk(27, 59, 37, 37), 1'b1, 1'b0, 1'b0);
      tick();
      push("hold_t3", pk(27, 59, 37, 37), 1'b1, 1'b0, 1'b0);
      tick();
      push("async_rst", CTR, 1'b0, 1'b0, 1'b1);
      @(negedge clk); armed = 1'b1; rst = 1'b1;
      @(negedge clk); rst = 1'b0; armed = 1'b0;
      push("post_rst_tick", CTR, 1'b0, 1'b0, 1'b1);
      tick();

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover_expectations: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
